// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional macro UART_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin group.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int IDW           = 2,
    parameter int START_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_clear_req,
    output logic [IDW-1:0]       grant_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam logic [1:0] S_IDLE          = 2'd0;
    localparam logic [1:0] S_START         = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY_LOW = 2'd2;
    localparam logic [1:0] S_WAIT_DONE     = 2'd3;

    localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);

`ifdef UART_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               timeout_err_q, timeout_err_d;

    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     cand;
    logic               any_valid;
    logic               advance_ptr;
    logic [IDW-1:0]     next_ptr;

    function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Descending scan so the smallest offset from rr_ptr wins; requester 0 is
    // excluded from the rotation when it has its own priority lane.
    always_comb begin
        sel       = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_idx(int'(rr_ptr_q), k);
            if (req_valid[cand] && !(PRIO_EN && cand == '0)) begin
                sel       = cand;
                any_valid = 1'b1;
            end
        end
        if (PRIO_EN && req_valid[0]) begin
            sel       = '0;
            any_valid = 1'b1;
        end
    end

    always_comb begin
        next_ptr    = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
        advance_ptr = !(PRIO_EN && grant_id_q == '0);
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        req_ready_d   = '0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (any_valid) begin
                    tx_data_d        = req_data[8*sel +: 8];
                    grant_id_d       = sel;
                    req_ready_d[sel] = 1'b1;
                    tx_start_d       = 1'b1;
                    state_d          = S_START;
                end
            end
            S_START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    if (advance_ptr) begin
                        rr_ptr_d = next_ptr;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                tx_start_d = 1'b0;
                if (tx_clear_req) begin
                    if (advance_ptr) begin
                        rr_ptr_d = next_ptr;
                    end
                    state_d = S_WAIT_BUSY_LOW;
                end
            end
            S_WAIT_BUSY_LOW: begin
                // Hold off re-arbitration until the UART stops reporting busy.
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            req_ready_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            req_ready_q   <= req_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign arb_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: reset, single transfer, fairness, timeout, corner cases.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_clear_req;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    int tests_run;
    int tests_failed;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .IDW(2),
        .START_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_clear_req(tx_clear_req),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a granted frame from START through busy/clear back to IDLE.
    task automatic finish_frame;
        tx_busy = 1'b1;
        tick();
        tx_clear_req = 1'b1;
        tick();
        tx_clear_req = 1'b0;
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        req_valid = 4'hF;
        req_data = 32'h44332211;
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
        tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_arb_busy: got %b expected 0", arb_busy); end
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL release_req_ready: got %b expected 0001", req_ready); end
        tests_run++; if (tx_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL release_tx_data: got %h expected 11", tx_data); end
        tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_tx_start: got %b expected 1", tx_start); end
        req_valid = 4'b0000;
        finish_frame();
        tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_back_idle: got %b expected 0", arb_busy); end
    endtask

    task automatic test_single;
        req_data = 32'h005A0000;
        req_valid = 4'b0100;
        tick();
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_req_ready: got %b expected 0100", req_ready); end
        tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL single_grant: got %0d expected 2", grant_id); end
        tests_run++; if (tx_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL single_tx_data: got %h expected 5a", tx_data); end
        req_valid = 4'b0000;
        tick();
        tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_start_held: got %b expected 1", tx_start); end
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        tx_busy = 1'b1;
        tick();
        tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_start_drop: got %b expected 0", tx_start); end
        tx_clear_req = 1'b1;
        tick();
        tx_clear_req = 1'b0;
        tick();
        tests_run++; if (arb_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_wait_busy_low: got %b expected 1", arb_busy); end
        tests_run++; if (tx_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL single_data_stable: got %h expected 5a", tx_data); end
        tx_busy = 1'b0;
        tick();
        tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle: got %b expected 0", arb_busy); end
        // rr_ptr should now be 3, so 3 beats 0
        req_valid = 4'b1001;
        tick();
        tests_run++; if (grant_id !== 2'd3) begin tests_failed++; $display("[TB] FAIL single_rr_ptr: got %0d expected 3", grant_id); end
        req_valid = 4'b0000;
        finish_frame();
    endtask

    task automatic test_fairness;
        logic [1:0] order [5];
        logic [7:0] bytes [4];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bytes = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        req_data = 32'hD3C2B1A0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++; if (grant_id !== order[k]) begin tests_failed++; $display("[TB] FAIL fair_grant%0d: got %0d expected %0d", k, grant_id, order[k]); end
            tests_run++; if (req_ready !== (4'b0001 << order[k])) begin tests_failed++; $display("[TB] FAIL fair_ready%0d: got %b expected %b", k, req_ready, 4'b0001 << order[k]); end
            tests_run++; if (tx_data !== bytes[order[k]]) begin tests_failed++; $display("[TB] FAIL fair_data%0d: got %h expected %h", k, tx_data, bytes[order[k]]); end
            finish_frame();
            tests_run++; if (arb_busy !== 1'b0 || req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL fair_gap%0d: got busy=%b ready=%b expected busy=0 ready=0000", k, arb_busy, req_ready); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout;
        int high_cycles;
        int guard;
        req_data = 32'h00CCBB00;
        req_valid = 4'b0110;
        tick();
        tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL to_grant: got %0d expected 1", grant_id); end
        high_cycles = 0;
        guard = 0;
        while (tx_start === 1'b1 && guard < 40) begin
            high_cycles++;
            guard++;
            tick();
        end
        tests_run++; if (high_cycles != 16) begin tests_failed++; $display("[TB] FAIL to_start_cycles: got %0d expected 16", high_cycles); end
        tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_err_pulse: got %b expected 1", timeout_err); end
        tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_idle: got %b expected 0", arb_busy); end
        tick();
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_err_one_cycle: got %b expected 0", timeout_err); end
        tests_run++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL to_next_grant: got id=%0d ready=%b expected id=2 ready=0100", grant_id, req_ready); end
        tests_run++; if (tx_data !== 8'hCC) begin tests_failed++; $display("[TB] FAIL to_next_data: got %h expected cc", tx_data); end
        req_valid = 4'b0000;
        finish_frame();
    endtask

    task automatic test_corner_cases;
        // Busy already high when START is entered.
        req_data = 32'h00000077;
        req_valid = 4'b0001;
        tx_busy = 1'b1;
        tick();
        tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL early_busy_grant: got %0d expected 0", grant_id); end
        req_valid = 4'b0000;
        tick();
        tests_run++; if (tx_start !== 1'b0 || arb_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL early_busy_accept: got start=%b busy=%b expected start=0 busy=1", tx_start, arb_busy); end
        tx_clear_req = 1'b1;
        tick();
        tx_clear_req = 1'b0;
        tx_busy = 1'b0;
        tick();
        // Clear in START is ignored; waiting requester 2 gets no ready.
        req_valid = 4'b0110;
        tick();
        tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL clr_start_grant: got %0d expected 1", grant_id); end
        tx_clear_req = 1'b1;
        tick();
        tx_clear_req = 1'b0;
        tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_start_ignored: got %b expected 1", tx_start); end
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL clr_no_ready: got %b expected 0000", req_ready); end
        finish_frame();
        tick();
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL pending_served: got %b expected 0100", req_ready); end
        req_valid = 4'b0000;
        finish_frame();
    endtask

    task automatic test_reset_mid;
        req_data = 32'h00990000;
        req_valid = 4'b0100;
        tick();
        tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL mid_grant: got %0d expected 2", grant_id); end
        req_valid = 4'b0000;
        tx_busy = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++; if (arb_busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL mid_reset_state: got busy=%b start=%b data=%h id=%0d expected all 0", arb_busy, tx_start, tx_data, grant_id); end
        tx_busy = 1'b0;
        tx_clear_req = 1'b1;
        tick();
        tx_clear_req = 1'b0;
        tick();
        tests_run++; if (arb_busy !== 1'b0 || req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mid_clear_ignored: got busy=%b ready=%b expected busy=0 ready=0000", arb_busy, req_ready); end
        req_valid = 4'b1010;
        tick();
        tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL mid_rr_reset: got %0d expected 1", grant_id); end
        req_valid = 4'b0000;
        finish_frame();
    endtask

`ifdef UART_ARB_PRIO_EN
    task automatic test_prio;
        logic [1:0] order [6];
        order = '{2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        finish_frame();
        for (int k = 0; k < 6; k++) begin
            req_valid = (order[k] == 2'd0) ? 4'b1111 : 4'b1110;
            tick();
            tests_run++; if (grant_id !== order[k]) begin tests_failed++; $display("[TB] FAIL prio_grant%0d: got %0d expected %0d", k, grant_id, order[k]); end
            finish_frame();
        end
        req_valid = 4'b0000;
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_data = 32'h0;
        tx_busy = 1'b0;
        tx_clear_req = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_corner_cases();
        test_reset_mid();
`ifdef UART_ARB_PRIO_EN
        test_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
